// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding memory request, in-order instruction buffer, redirect handling.
// Define IFETCH_ALIGN_CHECK_EN to add the fetch_fault output for misaligned redirect targets.
module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic [31:0]   out_instr_q, out_instr_d;
  logic [31:0]   buf_pc_q    [FIFO_DEPTH];
  logic [31:0]   buf_instr_q [FIFO_DEPTH];

  logic          push, pop, halt;
  logic [CW-1:0] level, kept;
  logic [31:0]   target;

  assign target = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign halt        = fault_q;
  assign fetch_fault = fault_q;
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    pop   = out_valid_q & out_ready;
    // Buffer slots committed after this cycle; a WAIT request counts whether or not its word arrives now.
    level = count_q - CW'(pop) + CW'(state_q == WAIT);
    imem_req  = rst_n & ~redirect_valid & ~halt & (level < CW'(FIFO_DEPTH)) &
                ((state_q == IDLE) | ((state_q == WAIT) & imem_rvalid));
    imem_addr = pc_q;
    push      = imem_rvalid & (state_q == WAIT) & ~redirect_valid;

    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (imem_req & imem_gnt) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
    case (state_q)
      IDLE:    if (imem_req & imem_gnt) state_d = WAIT;
      WAIT:    if (imem_rvalid) state_d = (imem_req & imem_gnt) ? WAIT : IDLE;
      DROP:    if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d    = target;
      state_d = (state_q != IDLE && !imem_rvalid) ? DROP : IDLE;
    end

    kept = count_q - CW'(pop);
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = kept + CW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
    end

    // The output register mirrors the next head: an older buffered word, else the word arriving now.
    out_valid_d = (count_d != '0);
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (kept != '0) begin
      out_pc_d    = buf_pc_q[rd_ptr_d];
      out_instr_d = buf_instr_q[rd_ptr_d];
    end else if (push) begin
      out_pc_d    = req_pc_q;
      out_instr_d = imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= req_pc_q;
      buf_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed scenarios plus randomized memory/decode traffic, checked
// against a transaction-level model of the expected fetch address and instruction streams.
`timescale 1ns/1ps
module tb_ifetch;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] MAGIC  = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: next PC decode must see, next address the fetcher must request,
  // and words delivered by memory but not yet consumed.
  logic [31:0] exp_pc;
  logic [31:0] fetch_pc;
  int          buffered;

  // Memory model: a single pending response with a countdown.
  bit          pend_valid = 0;
  bit          pend_stale = 0;
  int          pend_delay = 0;
  logic [31:0] pend_addr  = '0;

  int          gnt_pct   = 100;
  int          ready_pct = 100;
  int          lat_min   = 1;
  int          lat_max   = 1;
  bit          do_redirect = 0;
  logic [31:0] redir_target = '0;

  bit          prev_req_waiting = 0;
  logic [31:0] prev_addr = '0;
  bit          last_req = 0;
  bit          last_gnt = 0;
  logic [31:0] last_gnt_addr = '0;
  logic [31:0] last_xfer_pc = '0;
  int          transfers = 0;
  bit          saw_zero = 0;

  always #5 clk = ~clk;

  ifetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, answer the request, update the model.
  task automatic applyStimulus();
    bit          gnt, rv, xfer;
    logic [31:0] tgt;
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, buffered != 0});
    out_ready      = ($urandom_range(99) < ready_pct);
    redirect_valid = do_redirect;
    redirect_pc    = redir_target;
    rv             = pend_valid && (pend_delay == 0);
    imem_rvalid    = rv;
    imem_rdata     = rv ? (pend_addr ^ MAGIC) : $urandom;
    #2;
    if (prev_req_waiting && !redirect_valid) begin
      checkOutput("req_hold", {31'b0, imem_req}, 32'd1);
      checkOutput("addr_hold", imem_addr, prev_addr);
    end
    checkOutput("one_outstanding", {31'b0, imem_req && pend_valid && !rv}, 32'd0);
    gnt      = imem_req && ($urandom_range(99) < gnt_pct);
    imem_gnt = gnt;
    #2;
    xfer = out_valid && out_ready && !redirect_valid;
    if (xfer) begin
      checkOutput("out_pc", out_pc, exp_pc);
      checkOutput("out_instr", out_instr, exp_pc ^ MAGIC);
      last_xfer_pc = out_pc;
      if (out_pc == 32'h0) saw_zero = 1;
      transfers++;
      exp_pc = exp_pc + 32'd4;
      buffered--;
    end
    if (redirect_valid) begin
      tgt      = redirect_pc & 32'hFFFF_FFFC;
      exp_pc   = tgt;
      fetch_pc = tgt;
      buffered = 0;
      if (pend_valid && !rv) pend_stale = 1;
    end
    if (gnt) begin
      checkOutput("imem_addr", imem_addr, fetch_pc);
      fetch_pc = fetch_pc + 32'd4;
    end
    if (rv && !pend_stale && !redirect_valid) buffered++;
    if (rv) pend_valid = 0;
    else if (pend_valid) pend_delay--;
    if (gnt) begin
      pend_valid = 1;
      pend_stale = 0;
      pend_addr  = imem_addr;
      pend_delay = $urandom_range(lat_max, lat_min) - 1;
    end
    prev_req_waiting = imem_req && !gnt && !redirect_valid;
    prev_addr        = imem_addr;
    last_req         = imem_req;
    last_gnt         = gnt;
    last_gnt_addr    = imem_addr;
    do_redirect      = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input bit stale_resp);
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    #2;
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
    checkOutput("rst_fault", {31'b0, fetch_fault}, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n            = 1'b1;
    exp_pc           = RST_PC;
    fetch_pc         = RST_PC;
    buffered         = 0;
    prev_req_waiting = 0;
    if (stale_resp && pend_valid) begin
      pend_stale = 1;
      pend_delay = 0;
    end else begin
      pend_valid = 0;
    end
    #1;
    checkOutput("first_req", {31'b0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, RST_PC);
  endtask

  task automatic waitTransfer(input string tag, input logic [31:0] exp);
    int start = transfers;
    int n = 0;
    while (transfers == start && n < 40) begin
      applyStimulus();
      n++;
    end
    if (transfers == start) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    else checkOutput(tag, last_xfer_pc, exp);
  endtask

  task automatic waitGrant(input logic [31:0] addr);
    int n = 0;
    while (!(last_gnt && last_gnt_addr == addr) && n < 40) begin
      applyStimulus();
      n++;
    end
    checkOutput("grant_seen", {31'b0, last_gnt && last_gnt_addr == addr}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    rst_n = 1'b1;
    #1;
    doReset(0);

    // Zero-wait streaming: one instruction per cycle once the pipeline fills.
    repeat (4) applyStimulus();
    start = transfers;
    repeat (16) applyStimulus();
    checkOutput("throughput", transfers - start, 32'd16);

    // Backpressure: buffer fills to depth, requests stop, then drains in order.
    ready_pct = 0;
    repeat (10) applyStimulus();
    checkOutput("hold_buffered", buffered, DEPTH);
    checkOutput("hold_req", {31'b0, last_req}, 32'd0);
    ready_pct = 100;
    repeat (6) applyStimulus();

    // Redirect while a slow response is outstanding: stale word dropped.
    lat_min = 3;
    lat_max = 3;
    doReset(0);
    waitGrant(32'h8);
    applyStimulus();
    do_redirect  = 1;
    redir_target = 32'h100;
    applyStimulus();
    waitTransfer("drop_first_pc", 32'h100);

    // Redirect in the same cycle as rvalid.
    lat_min = 1;
    lat_max = 1;
    doReset(0);
    repeat (5) applyStimulus();
    do_redirect  = 1;
    redir_target = 32'h40;
    applyStimulus();
    waitTransfer("same_cycle_pc", 32'h40);

    // Address wrap at the top of memory.
    saw_zero     = 0;
    do_redirect  = 1;
    redir_target = 32'hFFFF_FFF8;
    applyStimulus();
    waitTransfer("wrap_first_pc", 32'hFFFF_FFF8);
    repeat (4) applyStimulus();
    checkOutput("wrap_reached_zero", {31'b0, saw_zero}, 32'd1);

`ifdef IFETCH_ALIGN_CHECK_EN
    do_redirect  = 1;
    redir_target = 32'h102;
    applyStimulus();
    checkOutput("fault_set", {31'b0, fetch_fault}, 32'd1);
    repeat (3) applyStimulus();
    checkOutput("fault_halt_req", {31'b0, last_req}, 32'd0);
    checkOutput("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    do_redirect  = 1;
    redir_target = 32'h200;
    applyStimulus();
    checkOutput("fault_clear", {31'b0, fetch_fault}, 32'd0);
    waitTransfer("fault_resume_pc", 32'h200);
`else
    do_redirect  = 1;
    redir_target = 32'h102;
    applyStimulus();
    waitTransfer("misaligned_masked_pc", 32'h100);
`endif

    // Reset while a response is pending; it returns right after reset and must be ignored.
    lat_min = 3;
    lat_max = 3;
    doReset(0);
    repeat (5) applyStimulus();
    lat_min = 1;
    lat_max = 1;
    doReset(1);
    waitTransfer("post_reset_pc", RST_PC);
    repeat (6) applyStimulus();

    // Randomized traffic.
    doReset(0);
    start = transfers;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        gnt_pct   = $urandom_range(100, 30);
        ready_pct = $urandom_range(100, 20);
        lat_min   = 1;
        lat_max   = $urandom_range(4, 1);
      end
      if ($urandom_range(99) < 3) begin
        do_redirect  = 1;
        redir_target = $urandom & 32'hFFFF_FFFC;
      end
      applyStimulus();
    end
    checkOutput("random_progress", {31'b0, (transfers - start) >= 50}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction buffer entries (power of two, >= 2).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch byte address, word aligned.
REQ-007 imem_gnt  input  1  memory accepted request this cycle.
REQ-008 imem_rvalid  input  1  read data valid.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump/trap redirect strobe.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 out_valid  output  1  instruction available to decode.
REQ-013 out_pc  output  32  PC of out_instr.
REQ-014 out_instr  output  32  fetched instruction.
REQ-015 out_ready  input  1  decode accepts (transfer when out_valid & out_ready).
REQ-016 fetch_fault  output  1  misaligned redirect target (present only with IFETCH_ALIGN_CHECK_EN).

Function
REQ-017 Internal fetch PC register; next PC = PC + 4 on every grant, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-018 States: IDLE (nothing outstanding), WAIT (one granted request awaiting rvalid), DROP (outstanding response to discard).
REQ-019 At most one granted request outstanding at any time.
REQ-020 imem_req asserted when FIFO count + outstanding < FIFO_DEPTH and (state IDLE, or state WAIT with imem_rvalid=1 this cycle); otherwise low.
REQ-021 imem_addr = fetch PC; imem_req and imem_addr held stable until imem_gnt, except on redirect.
REQ-022 IDLE -> WAIT on imem_req & imem_gnt; WAIT -> IDLE on imem_rvalid without new grant; WAIT -> WAIT on rvalid plus same-cycle grant.
REQ-023 imem_rvalid in WAIT pushes {PC of request, imem_rdata} into FIFO; imem_rvalid is never earlier than the cycle after grant.
REQ-024 imem_rvalid in IDLE is ignored.
REQ-025 out_valid/out_pc/out_instr registered from FIFO head; first instruction visible the cycle after its rvalid.
REQ-026 FIFO pops on out_valid & out_ready; push and pop in the same cycle allowed when full; order preserved.
REQ-027 Sustained throughput with zero-wait memory (gnt with req, rvalid next cycle) and out_ready=1: one instruction per cycle.
REQ-028 redirect_valid: FIFO flushed and out_valid low next cycle; fetch PC <= redirect_pc; ungranted request withdrawn or retargeted.
REQ-029 Redirect in WAIT without same-cycle rvalid -> DROP; in DROP the next imem_rvalid is discarded, then -> IDLE; no request issued in DROP.
REQ-030 Redirect has priority over same-cycle rvalid and pop: the returning word is discarded, state -> IDLE.
REQ-031 Redirect in DROP stays in DROP and updates the PC.
REQ-032 imem_req may be asserted with redirect_pc in the cycle after redirect when in IDLE.

Reset
REQ-033 rst_n low asynchronously forces: state IDLE, PC = RESET_PC, FIFO empty, imem_req=0, out_valid=0, out_pc=0, out_instr=0, fetch_fault=0.
REQ-034 First imem_req (addr RESET_PC) in the first cycle after rst_n deasserts.
REQ-035 Reset mid-transaction abandons the outstanding request; any rvalid before the first new grant is ignored.

Configuration
REQ-036 Macro IFETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0] != 0 sets fetch_fault sticky, halts fetch (imem_req=0), and only reset or an aligned redirect clears it.
REQ-037 Macro undefined: fetch_fault port absent; redirect_pc[1:0] ignored and forced to 0.

Verification
REQ-038 Reset, zero-wait memory returning addr^32'hdeadbeef, out_ready=1 -> out_pc 0,4,8,... one per cycle, out_instr matches.
REQ-039 out_ready=0 for 10 cycles -> exactly FIFO_DEPTH words buffered, imem_req low, no loss; release -> in-order drain.
REQ-040 Grant at addr 0x8, rvalid delayed 3 cycles, redirect to 0x100 during wait -> stale word dropped, next out_pc=0x100.
REQ-041 Redirect to 0x40 in the same cycle as rvalid -> word discarded, out_valid low next cycle, next out_pc=0x40.
REQ-042 Redirect to 0xFFFF_FFF8 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-043 IFETCH_ALIGN_CHECK_EN defined, redirect to 0x102 -> fetch_fault=1, imem_req=0; aligned redirect to 0x200 -> fault clears, fetch resumes at 0x200.
